msgpass_buffer_mp: RTL and testbench

Parametrised multi-port message-passing buffer for the layered LDPC decoder datapath. It holds NUM_PORTS independent write and read ports on a single clock domain. It resolves same-address write collisions deterministically instead of corrupting data, and tracks which entries have been written since reset. Sits between the check-node/variable-node units and the message-shuffling network; supersedes the two-port dummy buffer model in both testbench and RTL.

---
 rtl/msgpass_buffer_mp_if.sv | 46 ++++
 rtl/msgpass_buffer_mp.sv | 187 ++++++++++++++++++
 tb/tb_msgpass_buffer_mp.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/msgpass_buffer_mp_if.sv
// rtl/msgpass_buffer_mp_if.sv - port bundle for the multi-port message-passing buffer
//
// Groups every per-port write/read signal of msgpass_buffer_mp. The clock and
// reset stay outside the bundle.
//   master : the datapath side (check-node/variable-node units, shuffler)
//   slave  : the buffer itself
// Signals (port p packed at [p*W +: W]):
//   wen_i          write enable, active low, NUM_PORTS
//   waddr_i        write address, NUM_PORTS*ADDR_WIDTH
//   wdata_i        write data, NUM_PORTS*DATA_WIDTH
//   ren_i          read enable, active high, NUM_PORTS
//   raddr_i        read address, NUM_PORTS*ADDR_WIDTH
//   rdata_o        registered read data, NUM_PORTS*DATA_WIDTH
//   rvalid_o       read data valid, NUM_PORTS
//   rinit_o        returned entry was written since reset, NUM_PORTS
//   conflict_o     pulse: this port's write was dropped, NUM_PORTS
//   conflict_cnt_o saturating dropped-write count, CNT_WIDTH
//   clr_cnt_i      synchronous clear of the dropped-write count
interface msgpass_buffer_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_PORTS  = 2,
    parameter int CNT_WIDTH  = 16
);
    logic [NUM_PORTS-1:0]            wen_i;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] waddr_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_PORTS-1:0]            ren_i;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] raddr_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_o;
    logic [NUM_PORTS-1:0]            rvalid_o;
    logic [NUM_PORTS-1:0]            rinit_o;
    logic [NUM_PORTS-1:0]            conflict_o;
    logic [CNT_WIDTH-1:0]            conflict_cnt_o;
    logic                            clr_cnt_i;

    modport master (
        output wen_i, waddr_i, wdata_i, ren_i, raddr_i, clr_cnt_i,
        input  rdata_o, rvalid_o, rinit_o, conflict_o, conflict_cnt_o
    );

    modport slave (
        input  wen_i, waddr_i, wdata_i, ren_i, raddr_i, clr_cnt_i,
        output rdata_o, rvalid_o, rinit_o, conflict_o, conflict_cnt_o
    );
endinterface

// File: rtl/msgpass_buffer_mp.sv
// rtl/msgpass_buffer_mp.sv - multi-port message-passing buffer with write arbitration
//
// NUM_PORTS write ports and NUM_PORTS read ports on one clock. Same-address
// write collisions are resolved in favour of the lowest-indexed port; losers
// and out-of-range writes are dropped, flagged on conflict_o one cycle later
// and counted in a saturating counter. A DEPTH-bit bitmap records which
// entries were written since reset; unwritten entries read back as 0.
// Optional feature: define MSGPASS_BUFF_WR_FORWARD_EN to forward a winning
// write to a same-cycle read of the same address.
// Ports:
//   clk_i  rising-edge clock
//   rstn   asynchronous active-low reset
//   bus    msgpass_buffer_mp_if.slave (all write/read/conflict signals)
module msgpass_buffer_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_PORTS  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn,
    msgpass_buffer_mp_if.slave   bus
);

    // Sum is wide enough to add up to 8 drops to a saturated count.
    localparam int SUM_W = CNT_WIDTH + 4;
    localparam logic [SUM_W-1:0]      CNT_MAX = {{4{1'b0}}, {CNT_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      written_q;

    logic [ADDR_WIDTH-1:0] waddr_a [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] raddr_a [NUM_PORTS];
    logic [NUM_PORTS-1:0]  wr_req;
    logic [NUM_PORTS-1:0]  win;
    logic [NUM_PORTS-1:0]  drop;
    logic [NUM_PORTS-1:0]  rd_in_range;
    logic [SUM_W-1:0]      drop_cnt;
    logic [SUM_W-1:0]      cnt_sum;
    logic [CNT_WIDTH-1:0]  cnt_next;

    logic [DATA_WIDTH-1:0] rdata_q [NUM_PORTS];
    logic [NUM_PORTS-1:0]  rvalid_q;
    logic [NUM_PORTS-1:0]  rinit_q;
    logic [NUM_PORTS-1:0]  conflict_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

`ifdef MSGPASS_BUFF_WR_FORWARD_EN
    logic [NUM_PORTS-1:0]  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data [NUM_PORTS];
`endif

    // Unpack the flat buses into per-port fields.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            waddr_a[p] = bus.waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_a[p] = bus.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            raddr_a[p] = bus.raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            rd_in_range[p] = ({1'b0, raddr_a[p]} < DEPTH_W);
        end
    end

    // Write arbitration: a request wins when its address is in range and no
    // lower-indexed port requests the same address. Winners therefore always
    // target distinct entries, so the memory loop below never double-writes.
    always_comb begin
        wr_req   = ~bus.wen_i;
        win      = '0;
        drop     = '0;
        drop_cnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            logic clash;
            clash = 1'b0;
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (q < p && wr_req[q] && waddr_a[q] == waddr_a[p]) begin
                    clash = 1'b1;
                end
            end
            win[p]  = wr_req[p] && !clash && ({1'b0, waddr_a[p]} < DEPTH_W);
            drop[p] = wr_req[p] && !win[p];
            drop_cnt = drop_cnt + SUM_W'(drop[p]);
        end
    end

`ifdef MSGPASS_BUFF_WR_FORWARD_EN
    // At most one winner per address, so any matching winner is the one.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            fwd_hit[p]  = 1'b0;
            fwd_data[p] = '0;
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (win[q] && waddr_a[q] == raddr_a[p]) begin
                    fwd_hit[p]  = 1'b1;
                    fwd_data[p] = wdata_a[q];
                end
            end
        end
    end
`endif

    // Clear loads this cycle's drops instead of adding them to the old value.
    always_comb begin
        cnt_sum  = (bus.clr_cnt_i ? '0 : {{4{1'b0}}, cnt_q}) + drop_cnt;
        cnt_next = (cnt_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
    end

    // Storage is never reset; writes are simply ignored while rstn is low.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (rstn) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (win[p]) begin
                    mem[waddr_a[p]] <= wdata_a[p];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            written_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (win[p]) begin
                    written_q[waddr_a[p]] <= 1'b1;
                end
            end
        end
    end

    // Read path samples pre-write contents; forwarding, when built in,
    // overrides with the winning write of the same cycle.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rdata_q[p] <= '0;
            end
            rvalid_q <= '0;
            rinit_q  <= '0;
        end else begin
            rvalid_q <= bus.ren_i;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bus.ren_i[p]) begin
                    if (!rd_in_range[p]) begin
                        rdata_q[p] <= '0;
                        rinit_q[p] <= 1'b0;
`ifdef MSGPASS_BUFF_WR_FORWARD_EN
                    end else if (fwd_hit[p]) begin
                        rdata_q[p] <= fwd_data[p];
                        rinit_q[p] <= 1'b1;
`endif
                    end else if (written_q[raddr_a[p]]) begin
                        rdata_q[p] <= mem[raddr_a[p]];
                        rinit_q[p] <= 1'b1;
                    end else begin
                        rdata_q[p] <= '0;
                        rinit_q[p] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            conflict_q <= '0;
            cnt_q      <= '0;
        end else begin
            conflict_q <= drop;
            cnt_q      <= cnt_next;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q[p];
        end
    end

    assign bus.rvalid_o       = rvalid_q;
    assign bus.rinit_o        = rinit_q;
    assign bus.conflict_o     = conflict_q;
    assign bus.conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_msgpass_buffer_mp.sv
// tb/tb_msgpass_buffer_mp.sv - directed self-checking bench for msgpass_buffer_mp
module tb_msgpass_buffer_mp;

    localparam int DW = 32;
    localparam int DEPTH = 12;
    localparam int AW = 4;
    localparam int NP = 2;
    localparam int CW = 4;

    logic clk_i = 1'b0;
    logic rstn  = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    msgpass_buffer_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .CNT_WIDTH(CW)) bus ();

    msgpass_buffer_mp #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .CNT_WIDTH(CW)
    ) dut (
        .clk_i (clk_i),
        .rstn  (rstn),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.wen_i     = '1;
        bus.ren_i     = '0;
        bus.clr_cnt_i = 1'b0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wen_i[p] = 1'b0;
        bus.waddr_i[p*AW +: AW] = a;
        bus.wdata_i[p*DW +: DW] = d;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        bus.ren_i[p] = 1'b1;
        bus.raddr_i[p*AW +: AW] = a;
    endtask

    function automatic logic [31:0] rdata(input int p);
        return bus.rdata_o[p*DW +: DW];
    endfunction

    initial begin
        bus.waddr_i = '0;
        bus.wdata_i = '0;
        bus.raddr_i = '0;
        idle();
        rstn = 1'b0;
        tick(); tick();
        check("rst_rvalid",   32'(bus.rvalid_o), 32'h0);
        check("rst_rinit",    32'(bus.rinit_o), 32'h0);
        check("rst_rdata0",   rdata(0), 32'h0);
        check("rst_conflict", 32'(bus.conflict_o), 32'h0);
        check("rst_cnt",      32'(bus.conflict_cnt_o), 32'h0);
        rstn = 1'b1;
        tick();

        // Unwritten entry after reset.
        rd(0, 4'd5);
        tick();
        check("rd5_rvalid", 32'(bus.rvalid_o), 32'h1);
        check("rd5_rdata",  rdata(0), 32'h0);
        check("rd5_rinit",  32'(bus.rinit_o), 32'h0);
        idle();

        // Write then read on the other port, one-cycle latency.
        wr(0, 4'd3, 32'hA5A5_0001);
        tick();
        check("wr3_conflict", 32'(bus.conflict_o), 32'h0);
        check("wr3_rvalid",   32'(bus.rvalid_o), 32'h0);
        idle();
        rd(1, 4'd3);
        tick();
        check("rd3_rvalid", 32'(bus.rvalid_o), 32'h2);
        check("rd3_rdata",  rdata(1), 32'hA5A5_0001);
        check("rd3_rinit",  32'(bus.rinit_o[1]), 32'h1);
        idle();

        // Collision on addr 7: port 0 wins.
        wr(0, 4'd7, 32'h11);
        wr(1, 4'd7, 32'h22);
        tick();
        check("col_conflict", 32'(bus.conflict_o), 32'h2);
        check("col_cnt",      32'(bus.conflict_cnt_o), 32'h1);
        idle();
        rd(0, 4'd7);
        tick();
        check("col_pulse_end", 32'(bus.conflict_o), 32'h0);
        check("col_cnt_hold",  32'(bus.conflict_cnt_o), 32'h1);
        check("col_rdata",     rdata(0), 32'h11);
        check("col_rinit",     32'(bus.rinit_o[0]), 32'h1);
        idle();
        tick();
        check("hold_rvalid", 32'(bus.rvalid_o), 32'h0);
        check("hold_rdata",  rdata(0), 32'h11);

        // Saturation: 2^CW+3 colliding cycles.
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            wr(0, 4'd7, 32'h11);
            wr(1, 4'd7, 32'h22);
            tick();
        end
        check("sat_cnt", 32'(bus.conflict_cnt_o), 32'hF);
        bus.clr_cnt_i = 1'b1;
        tick();
        check("clr_col_cnt", 32'(bus.conflict_cnt_o), 32'h1);
        idle();
        bus.clr_cnt_i = 1'b1;
        tick();
        check("clr_idle_cnt", 32'(bus.conflict_cnt_o), 32'h0);
        idle();

        // Same-cycle write and read of addr 9.
        wr(0, 4'd9, 32'h33);
        tick();
        idle();
        wr(0, 4'd9, 32'h55);
        rd(1, 4'd9);
        tick();
`ifdef MSGPASS_BUFF_WR_FORWARD_EN
        check("rw9_rdata", rdata(1), 32'h55);
`else
        check("rw9_rdata", rdata(1), 32'h33);
`endif
        check("rw9_rinit", 32'(bus.rinit_o[1]), 32'h1);
        idle();
        rd(1, 4'd9);
        tick();
        check("rd9_after", rdata(1), 32'h55);
        idle();

        // Boundaries: last entry and out-of-range address.
        wr(1, 4'd11, 32'hDEAD_BEEF);
        wr(0, 4'd13, 32'h1234);
        tick();
        check("oor_conflict", 32'(bus.conflict_o), 32'h1);
        check("oor_cnt",      32'(bus.conflict_cnt_o), 32'h1);
        idle();
        rd(0, 4'd13);
        rd(1, 4'd11);
        tick();
        check("oor_rdata",  rdata(0), 32'h0);
        check("oor_rinit",  32'(bus.rinit_o), 32'h2);
        check("last_rdata", rdata(1), 32'hDEAD_BEEF);
        idle();

        // Reset during an in-flight read.
        wr(0, 4'd2, 32'h77);
        tick();
        idle();
        rd(0, 4'd2);
        tick();
        check("pre_rst_rdata", rdata(0), 32'h77);
        rd(0, 4'd2);
        wr(1, 4'd2, 32'h99);
        rstn = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(bus.rvalid_o), 32'h0);
        check("mid_rst_rdata",  rdata(0), 32'h0);
        tick();
        check("mid_rst_rvalid2", 32'(bus.rvalid_o), 32'h0);
        rstn = 1'b1;
        idle();
        rd(0, 4'd2);
        tick();
        check("post_rst_rvalid", 32'(bus.rvalid_o), 32'h1);
        check("post_rst_rdata",  rdata(0), 32'h0);
        check("post_rst_rinit",  32'(bus.rinit_o), 32'h0);
        check("post_rst_cnt",    32'(bus.conflict_cnt_o), 32'h0);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
